// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: owns hh:mm:ss, debounces the mode/inc buttons,
// and drives the blink mask and decimal points for the six-digit display.
module clock_set_ctrl #(
    parameter int DEB_CYCLES   = 500000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic [5:0] o_blank,
    output logic [5:0] o_dp
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [5:0] DP_COLON = 6'b010100;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } mode_t;

    logic [1:0]    w_raw;
    logic [1:0]    w_press;
    logic          w_mode_press;
    logic          w_inc_press;
    mode_t         r_mode;
    mode_t         w_mode_next;
    logic [5:0]    r_sec, r_min;
    logic [5:0]    w_sec_next, w_min_next;
    logic [4:0]    r_hour, w_hour_next;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_next;
    logic          r_phase, w_phase_next;
    logic [5:0]    r_blank, r_dp;
    logic [5:0]    w_blank_next, w_dp_next;

    assign w_raw = {i_btn_inc, i_btn_mode};

    // Each button: 2-flop sync, run-length of the synchronized level, and an
    // arm flag so a button held through reset must be released before it counts.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          r_sync0, r_sync1, r_last, r_level, r_armed, r_press;
            logic [DW-1:0] r_run;
            logic [DW-1:0] w_run;
            logic          w_stable;

            always_comb begin
                if (r_sync1 != r_last)
                    w_run = DW'(1);
                else if (r_run == DW'(DEB_CYCLES))
                    w_run = r_run;
                else
                    w_run = r_run + 1'b1;
            end

            assign w_stable = (w_run == DW'(DEB_CYCLES));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync0 <= 1'b0;
                    r_sync1 <= 1'b0;
                    r_last  <= 1'b0;
                    r_run   <= '0;
                    r_level <= 1'b0;
                    r_armed <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_sync0 <= w_raw[gi];
                    r_sync1 <= r_sync0;
                    r_last  <= r_sync1;
                    r_run   <= w_run;
                    r_press <= 1'b0;
                    if (w_stable) begin
                        r_level <= r_sync1;
                        if (!r_sync1)
                            r_armed <= 1'b1;
                        if (r_sync1 && !r_level && r_armed)
                            r_press <= 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    assign w_mode_press = w_press[0];
    assign w_inc_press  = w_press[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mode <= RUN;
        else
            r_mode <= w_mode_next;
    end

    // Next state
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_press) begin
            case (r_mode)
                RUN:      w_mode_next = SET_SEC;
                SET_SEC:  w_mode_next = SET_MIN;
                SET_MIN:  w_mode_next = SET_HOUR;
                SET_HOUR: w_mode_next = RUN;
                default:  w_mode_next = RUN;
            endcase
        end
    end

    // Time datapath: carries only while running, single-field wrap while editing.
    always_comb begin
        w_sec_next  = r_sec;
        w_min_next  = r_min;
        w_hour_next = r_hour;
        if (r_mode == RUN) begin
            if (i_tick_1hz) begin
                if (r_sec == 6'd59) begin
                    w_sec_next = 6'd0;
                    if (r_min == 6'd59) begin
                        w_min_next  = 6'd0;
                        w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                    end else begin
                        w_min_next = r_min + 6'd1;
                    end
                end else begin
                    w_sec_next = r_sec + 6'd1;
                end
            end
        end else if (w_inc_press && !w_mode_press) begin
            case (r_mode)
                SET_SEC:  w_sec_next  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                SET_MIN:  w_min_next  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                SET_HOUR: w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
        w_phase_next     = r_phase;
        if (w_mode_next != r_mode) begin
            w_blink_cnt_next = '0;
            w_phase_next     = 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            w_blink_cnt_next = '0;
            w_phase_next     = ~r_phase;
        end
    end

    // Outputs, derived from next-state values so they land with o_mode.
    always_comb begin
        w_blank_next = 6'b000000;
        w_dp_next    = DP_COLON;
        case (w_mode_next)
            RUN:      w_dp_next = w_sec_next[0] ? DP_COLON : 6'b000000;
            SET_SEC:  if (w_phase_next) w_blank_next = 6'b000011;
            SET_MIN:  if (w_phase_next) w_blank_next = 6'b001100;
            SET_HOUR: if (w_phase_next) w_blank_next = 6'b110000;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_blank     <= '0;
            r_dp        <= '0;
        end else begin
            r_sec       <= w_sec_next;
            r_min       <= w_min_next;
            r_hour      <= w_hour_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_phase     <= w_phase_next;
            r_blank     <= w_blank_next;
            r_dp        <= w_dp_next;
        end
    end

    assign o_sec   = r_sec;
    assign o_min   = r_min;
    assign o_hour  = r_hour;
    assign o_mode  = r_mode;
    assign o_blank = r_blank;
    assign o_dp    = r_dp;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: time-of-day model (seconds of day), window-based
// button model, per-cycle compare plus directed literal checks.
module tb_clock_set_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       tick   = 1'b0;
    logic       bm     = 1'b0;
    logic       bi     = 1'b0;
    logic [5:0] sec, mn, blank, dp;
    logic [4:0] hr;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick_1hz (tick),
        .i_btn_mode (bm),
        .i_btn_inc  (bi),
        .o_sec      (sec),
        .o_min      (mn),
        .o_hour     (hr),
        .o_mode     (mode),
        .o_blank    (blank),
        .o_dp       (dp)
    );

    // ---------------- reference model ----------------
    int             m_t    = 0;   // seconds since midnight
    int             m_mode = 0;
    int             m_k    = 0;   // cycles spent in current state
    bit             m_dly[2][2];
    logic [DEB-1:0] m_hist[2];
    int             m_nv[2];
    bit             m_deb[2];
    bit             m_armed[2];
    bit             m_press_q[2];

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_k = 0;
        for (int b = 0; b < 2; b++) begin
            m_dly[b][0] = 0; m_dly[b][1] = 0;
            m_hist[b] = '0; m_nv[b] = 0;
            m_deb[b] = 0; m_armed[b] = 0; m_press_q[b] = 0;
        end
    endtask

    task automatic model_step();
        bit pr[2];
        bit raw[2];
        bit syn;
        int old, f;
        raw[0] = bm;
        raw[1] = bi;
        for (int b = 0; b < 2; b++) begin
            pr[b] = m_press_q[b];
            syn = m_dly[b][1];                 // raw level seen two samples ago
            m_dly[b][1] = m_dly[b][0];
            m_dly[b][0] = raw[b];
            m_hist[b] = {m_hist[b][DEB-2:0], syn};
            if (m_nv[b] < DEB) m_nv[b]++;
            m_press_q[b] = 0;
            if (m_nv[b] == DEB && (m_hist[b] == '0 || m_hist[b] == '1)) begin
                if (syn && !m_deb[b] && m_armed[b]) m_press_q[b] = 1;
                if (!syn) m_armed[b] = 1;
                m_deb[b] = syn;
            end
        end
        old = m_mode;
        if (m_mode == 0) begin
            if (tick) m_t = (m_t + 1) % 86400;
            if (pr[0]) m_mode = 1;
        end else if (pr[0]) begin
            m_mode = (m_mode + 1) % 4;
        end else if (pr[1]) begin
            case (m_mode)
                1: begin f = m_t % 60;        m_t = m_t - f + (f + 1) % 60; end
                2: begin f = (m_t / 60) % 60; m_t = m_t - f * 60 + ((f + 1) % 60) * 60; end
                default: begin f = m_t / 3600; m_t = m_t - f * 3600 + ((f + 1) % 24) * 3600; end
            endcase
        end
        m_k = (m_mode != old) ? 0 : m_k + 1;
    endtask

    function automatic int exp_blank();
        if (m_mode == 0 || ((m_k / BLINK) % 2) == 0) return 0;
        if (m_mode == 1) return 6'b000011;
        if (m_mode == 2) return 6'b001100;
        return 6'b110000;
    endfunction

    function automatic int exp_dp();
        if (m_mode != 0) return 6'b010100;
        return ((m_t % 60) % 2 == 1) ? 6'b010100 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("sec",   int'(sec),   m_t % 60);
            check("min",   int'(mn),    (m_t / 60) % 60);
            check("hour",  int'(hr),    m_t / 3600);
            check("mode",  int'(mode),  m_mode);
            check("blank", int'(blank), exp_blank());
            check("dp",    int'(dp),    exp_dp());
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit t, input bit m, input bit i);
        @(negedge clk);
        tick = t; bm = m; bi = i;
    endtask

    task automatic press(input bit m, input bit i, input bit rt);
        repeat (6) step(rt && ($urandom_range(0, 3) == 0), m, i);
        repeat (7) step(rt && ($urandom_range(0, 3) == 0), 0, 0);
    endtask

    task automatic press_n(input bit m, input bit i, input int n);
        repeat (n) press(m, i, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sec"},   int'(sec),   0);
        check({tag, "_min"},   int'(mn),    0);
        check({tag, "_hour"},  int'(hr),    0);
        check({tag, "_mode"},  int'(mode),  0);
        check({tag, "_blank"}, int'(blank), 0);
        check({tag, "_dp"},    int'(dp),    0);
    endtask

    initial begin
        int j;
        bit rb_m, rb_i;

        // Reset state
        repeat (3) step(0, 0, 0);
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (10) step(0, 0, 0);

        // 61 ticks -> 00:01:01
        repeat (61) begin step(1, 0, 0); step(0, 0, 0); end
        check("t61_sec", int'(sec), 1);
        check("t61_min", int'(mn), 1);
        check("t61_hour", int'(hr), 0);
        check("t61_mode", int'(mode), 0);
        check("t61_dp", int'(dp), 6'b010100);

        // Preset 23:59:58 then roll over midnight
        press(1, 0, 0); press_n(0, 1, 57);
        press(1, 0, 0); press_n(0, 1, 58);
        press(1, 0, 0); press_n(0, 1, 23);
        press(1, 0, 0);
        check("preset_hour", int'(hr), 23);
        check("preset_min", int'(mn), 59);
        check("preset_sec", int'(sec), 58);
        step(1, 0, 0); step(0, 0, 0);
        check("roll1_sec", int'(sec), 59);
        check("roll1_hour", int'(hr), 23);
        step(1, 0, 0); step(0, 0, 0);
        check("roll2_sec", int'(sec), 0);
        check("roll2_min", int'(mn), 0);
        check("roll2_hour", int'(hr), 0);
        check("roll2_dp", int'(dp), 0);

        // Mode bounce: 1, 2, 3 cycle pulses, then held
        step(0, 1, 0); repeat (2) step(0, 0, 0);
        repeat (2) step(0, 1, 0); repeat (2) step(0, 0, 0);
        repeat (3) step(0, 1, 0); repeat (2) step(0, 0, 0);
        step(0, 1, 0);
        repeat (6) step(0, 1, 0);
        check("bounce_mode_early", int'(mode), 0);
        step(0, 1, 0);
        check("bounce_mode_edge", int'(mode), 1);
        repeat (2) step(0, 1, 0);
        repeat (8) step(0, 0, 0);
        check("bounce_mode_final", int'(mode), 1);

        // Mode + inc together in SET_SEC: mode wins
        repeat (6) step(0, 1, 1);
        step(0, 0, 0);
        j = 0;
        while (mode != 2'd2 && j < 20) begin step(0, 0, 0); j++; end
        check("modeinc_latency", j, 1);
        check("modeinc_mode", int'(mode), 2);
        check("modeinc_sec", int'(sec), 0);
        for (int n = 0; n < 24; n++) begin
            check("blink_mask", int'(blank), ((n / 8) % 2 == 1) ? 6'b001100 : 0);
            step(0, 0, 0);
        end

        // SET_MIN: 60 inc presses with random ticks
        repeat (60) press(0, 1, 1);
        check("min60_min", int'(mn), 0);
        check("min60_hour", int'(hr), 0);
        check("min60_sec", int'(sec), 0);
        check("min60_mode", int'(mode), 2);

        // Random traffic
        rb_m = 0; rb_i = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) rb_m = ~rb_m;
            if ($urandom_range(0, 5) == 0) rb_i = ~rb_i;
            step($urandom_range(0, 7) == 0, rb_m, rb_i);
        end
        repeat (10) step(0, 0, 0);

        // Clean reset, preset 12:34:56 in SET_HOUR
        @(negedge clk) rst_n = 1'b0;
        repeat (2) step(0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) step(0, 0, 0);
        press(1, 0, 0); press_n(0, 1, 56);
        press(1, 0, 0); press_n(0, 1, 34);
        press(1, 0, 0); press_n(0, 1, 12);
        check("p12_hour", int'(hr), 12);
        check("p12_min", int'(mn), 34);
        check("p12_sec", int'(sec), 56);
        check("p12_mode", int'(mode), 3);

        // Async reset mid-debounce with mode held through release
        repeat (2) step(0, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        repeat (3) step(0, 1, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) step(0, 1, 0);
        check("held_no_press", int'(mode), 0);
        repeat (10) step(0, 0, 0);
        press(1, 0, 0);
        check("repress_mode", int'(mode), 1);

        repeat (4) step(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
